// File: rtl/pool_window_buffer_pkg.sv
// Shared CNN helpers: FSM state type, counter sizing, window lane indexing and
// the legality rule for pooling geometry, reused by the window and pooling stages.
package pool_window_buffer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } pwb_state_e;

  // Counter width for a counter that must index 0..limit-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

  // Lane k of a packed window for row offset r and column offset c.
  function automatic int lane_idx(input int r, input int c, input int s);
    return r * s + c;
  endfunction

  function automatic bit params_legal(input int s, input int row_size, input int column_size);
    if (s < 1) return 1'b0;
    return (row_size >= s) && (column_size >= s) &&
           (row_size % s == 0) && (column_size % s == 0);
  endfunction

endpackage

// File: rtl/line_buffer_row.sv
// One stored image row: single write port, combinational read of STRIDE_SIZE
// consecutive entries starting at a window-aligned base column.
module line_buffer_row
  import pool_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int STRIDE_SIZE = 2,
  parameter int AW          = cnt_width(ROW_SIZE)
) (
  input  logic                            clock,
  input  logic                            i_wr_en,
  input  logic [AW-1:0]                   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  input  logic [AW-1:0]                   i_rd_base,
  output logic [STRIDE_SIZE*DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [ROW_SIZE];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  for (genvar gi = 0; gi < STRIDE_SIZE; gi++) begin : g_rd
    localparam logic [AW-1:0] OFS = AW'(gi);
    assign o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_rd_base + OFS];
  end

endmodule

// File: rtl/pool_window_buffer.sv
// Turns a raster pixel stream into non-overlapping STRIDE_SIZE x STRIDE_SIZE
// windows for the pooling stage; upper window rows come from line buffers.
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int COLUMN_SIZE = 4
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic [DATA_WIDTH-1:0]                       pixel_in,
  input  logic                                        pixel_valid,
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                        window_valid,
  output logic                                        frame_done
);

  localparam int WIN = STRIDE_SIZE * STRIDE_SIZE * DATA_WIDTH;
  localparam int CW  = cnt_width(ROW_SIZE);
  localparam int RW  = cnt_width(COLUMN_SIZE);
  localparam int PW  = cnt_width(STRIDE_SIZE);
  localparam int NLB = (STRIDE_SIZE > 1) ? STRIDE_SIZE - 1 : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(COLUMN_SIZE - 1);
  localparam logic [PW-1:0] PH_LAST      = PW'(STRIDE_SIZE - 1);
  localparam logic [PW-1:0] PH_FILL_LAST = PW'(STRIDE_SIZE - 2);

  if (!params_legal(STRIDE_SIZE, ROW_SIZE, COLUMN_SIZE)) begin : g_illegal
    $error("pool_window_buffer: ROW_SIZE/COLUMN_SIZE must be multiples of STRIDE_SIZE >= 1");
  end

  pwb_state_e            r_state, w_state_next;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [PW-1:0]         r_phase;
  logic [PW-1:0]         r_sub;
  logic                  w_accept, w_in_emit, w_fire;
  logic                  w_last_col, w_last_row, w_last_sub;
  logic [CW-1:0]         w_grp_base;
  logic [NLB-1:0]        w_lb_we;
  logic [STRIDE_SIZE*DATA_WIDTH-1:0] w_lb_rd [NLB];
  logic [DATA_WIDTH-1:0] r_shift [NLB];
  logic [WIN-1:0]        w_window;
  logic [WIN-1:0]        r_window_out;
  logic                  r_window_valid, r_frame_done;

  assign w_accept   = pixel_valid;
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);
  assign w_last_sub = (r_sub == PH_LAST);
  assign w_grp_base = r_col - CW'(r_sub);

  // r_sub is the column offset inside the current window (col mod STRIDE_SIZE).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_phase <= '0;
      r_sub   <= '0;
    end else if (w_accept) begin
      r_sub <= w_last_sub ? '0 : r_sub + 1'b1;
      if (w_last_col) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row   <= '0;
          r_phase <= '0;
        end else begin
          r_row   <= r_row + 1'b1;
          r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FILL;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (STRIDE_SIZE == 1) begin
      w_state_next = ST_EMIT;
    end else if (w_accept && w_last_col) begin
      if (r_state == ST_FILL && r_phase == PH_FILL_LAST) w_state_next = ST_EMIT;
      else if (r_state == ST_EMIT)                       w_state_next = ST_FILL;
    end
  end

  // With a 1x1 window every row is an output row, even straight out of reset.
  always_comb begin
    w_in_emit = (r_state == ST_EMIT) || (STRIDE_SIZE == 1);
    w_fire    = w_accept && w_in_emit && w_last_sub;
  end

  for (genvar gi = 0; gi < STRIDE_SIZE - 1; gi++) begin : g_lb
    assign w_lb_we[gi] = w_accept && !w_in_emit && (r_phase == PW'(gi));

    line_buffer_row #(
      .DATA_WIDTH (DATA_WIDTH),
      .ROW_SIZE   (ROW_SIZE),
      .STRIDE_SIZE(STRIDE_SIZE),
      .AW         (CW)
    ) u_line_buffer_row (
      .clock    (clock),
      .i_wr_en  (w_lb_we[gi]),
      .i_wr_addr(r_col),
      .i_wr_data(pixel_in),
      .i_rd_base(w_grp_base),
      .o_rd_data(w_lb_rd[gi])
    );
  end

  if (STRIDE_SIZE > 1) begin : g_shift
    always_ff @(posedge clock) begin
      if (w_accept && w_in_emit) begin
        for (int j = 0; j < NLB - 1; j++) r_shift[j] <= r_shift[j+1];
        r_shift[NLB-1] <= pixel_in;
      end
    end
  end

  // Bottom window row: earlier pixels from the shift register, last one straight from the input.
  for (genvar gr = 0; gr < STRIDE_SIZE; gr++) begin : g_win_r
    for (genvar gc = 0; gc < STRIDE_SIZE; gc++) begin : g_win_c
      localparam int K = lane_idx(gr, gc, STRIDE_SIZE);
      if (gr < STRIDE_SIZE - 1) begin : g_top
        assign w_window[K*DATA_WIDTH +: DATA_WIDTH] = w_lb_rd[gr][gc*DATA_WIDTH +: DATA_WIDTH];
      end else if (gc < STRIDE_SIZE - 1) begin : g_shift_lane
        assign w_window[K*DATA_WIDTH +: DATA_WIDTH] = r_shift[gc];
      end else begin : g_live
        assign w_window[K*DATA_WIDTH +: DATA_WIDTH] = pixel_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_window_out   <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_window_valid <= w_fire;
      r_frame_done   <= w_fire && w_last_col && w_last_row;
      if (w_fire) r_window_out <= w_window;
    end
  end

  assign window_out   = r_window_out;
  assign window_valid = r_window_valid;
  assign frame_done   = r_frame_done;

endmodule
